// File: rtl/bus_sched_pkg.sv
// Shared types and constants for the two-master memory bus scheduler.
//   state_e    : arbitration FSM states (idle, owned by m0, owned by m1)
//   GRANT_*    : one-hot grant encodings driven on grant_out
//   pick_owner : round-robin choice between two requesters
package bus_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // last_served: 0 = m0 was served last, 1 = m1 was served last.
    function automatic state_e pick_owner(input logic m0_req, input logic m1_req,
                                          input logic last_served);
        state_e owner;
        owner = StIdle;
        if (m0_req && m1_req) begin
            owner = last_served ? StOwn0 : StOwn1;
        end else if (m0_req) begin
            owner = StOwn0;
        end else if (m1_req) begin
            owner = StOwn1;
        end
        return owner;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Per-transaction wait counter for the bus scheduler.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_in     : reset the count (no transaction in flight or one is ending)
//   enable_in    : owned cycle with no slave response yet
//   expire_out   : high in the TIMEOUT-th consecutive enabled cycle
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_in,
    input  logic enable_in,
    output logic expire_out
);

    // Count runs 0..TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q, count_d;

    assign expire_out = enable_in && (count_q == CntLast);

    always_comb begin
        count_d = count_q;
        if (clear_in) begin
            count_d = '0;
        end else if (enable_in && !expire_out) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Round-robin owner of the shared memory bus between m0 (CPU side) and m1 (DMA/peripheral).
// A grant is held for a whole transaction; the slave response is routed to the owner only.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   mN_*_in                 : master N request (address, read, write, mask, write data)
//   mN_read_value_out       : read data to master N, zero unless completing master N
//   mN_ready_out/fault_out  : completion strobe / completion-with-fault to master N
//   address_out..write_value_out : shared bus, all-zero while idle
//   read_value_in, ready_in, fault_in : slave response
//   grant_out               : one-hot current owner (00 = idle)
//   timeout_count_out       : saturating count of timed-out transactions
// Build option: define BUS_TIMEOUT_EN to force a fault completion after TIMEOUT owned cycles
// without a slave response; otherwise the scheduler waits indefinitely.
module mem_bus_scheduler
    import bus_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] m0_address_in,
    input  logic        m0_read_in,
    input  logic        m0_write_in,
    input  logic [3:0]  m0_write_mask_in,
    input  logic [31:0] m0_write_value_in,
    output logic [31:0] m0_read_value_out,
    output logic        m0_ready_out,
    output logic        m0_fault_out,
    input  logic [31:0] m1_address_in,
    input  logic        m1_read_in,
    input  logic        m1_write_in,
    input  logic [3:0]  m1_write_mask_in,
    input  logic [31:0] m1_write_value_in,
    output logic [31:0] m1_read_value_out,
    output logic        m1_ready_out,
    output logic        m1_fault_out,
    output logic [31:0] address_out,
    output logic        read_out,
    output logic        write_out,
    output logic [3:0]  write_mask_out,
    output logic [31:0] write_value_out,
    input  logic [31:0] read_value_in,
    input  logic        ready_in,
    input  logic        fault_in,
    output logic [1:0]  grant_out,
    output logic [15:0] timeout_count_out
);

    if (TIMEOUT < 1) begin : gen_bad_timeout
        $error("mem_bus_scheduler: TIMEOUT must be at least 1");
    end

    state_e state_q, state_d;
    logic   last_q, last_d;

    logic m0_req, m1_req;
    logic owner_req;
    logic slave_resp;
    logic expire;
    logic done;

    assign m0_req     = m0_read_in | m0_write_in;
    assign m1_req     = m1_read_in | m1_write_in;
    assign slave_resp = ready_in | fault_in;
    assign owner_req  = ((state_q == StOwn0) && m0_req) || ((state_q == StOwn1) && m1_req);
    // Owner dropping its request is an abort, so completion needs the request still up.
    assign done       = owner_req && (slave_resp || expire);

`ifdef BUS_TIMEOUT_EN
    logic [15:0] timeout_cnt_q, timeout_cnt_d;

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_in   (!owner_req || done),
        .enable_in  (owner_req && !slave_resp),
        .expire_out (expire)
    );

    always_comb begin
        timeout_cnt_d = timeout_cnt_q;
        if (expire && (timeout_cnt_q != 16'hFFFF)) begin
            timeout_cnt_d = timeout_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt_q <= '0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign timeout_count_out = timeout_cnt_q;
`else
    assign expire            = 1'b0;
    assign timeout_count_out = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                state_d = pick_owner(m0_req, m1_req, last_q);
            end
            StOwn0: begin
                if (!m0_req) begin
                    state_d = StIdle;
                end else if (done) begin
                    last_d  = 1'b0;
                    state_d = m1_req ? StOwn1 : StIdle;
                end
            end
            StOwn1: begin
                if (!m1_req) begin
                    state_d = StIdle;
                end else if (done) begin
                    last_d  = 1'b1;
                    state_d = m0_req ? StOwn0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: bus mux and response routing, both keyed on the registered owner.
    always_comb begin
        grant_out         = GRANT_NONE;
        address_out       = '0;
        read_out          = 1'b0;
        write_out         = 1'b0;
        write_mask_out    = '0;
        write_value_out   = '0;
        m0_read_value_out = '0;
        m0_ready_out      = 1'b0;
        m0_fault_out      = 1'b0;
        m1_read_value_out = '0;
        m1_ready_out      = 1'b0;
        m1_fault_out      = 1'b0;
        unique case (state_q)
            StOwn0: begin
                grant_out       = GRANT_M0;
                address_out     = m0_address_in;
                read_out        = m0_read_in;
                write_out       = m0_write_in;
                write_mask_out  = m0_write_mask_in;
                write_value_out = m0_write_value_in;
                if (done) begin
                    m0_ready_out      = 1'b1;
                    m0_fault_out      = fault_in | expire;
                    m0_read_value_out = expire ? 32'h0 : read_value_in;
                end
            end
            StOwn1: begin
                grant_out       = GRANT_M1;
                address_out     = m1_address_in;
                read_out        = m1_read_in;
                write_out       = m1_write_in;
                write_mask_out  = m1_write_mask_in;
                write_value_out = m1_write_value_in;
                if (done) begin
                    m1_ready_out      = 1'b1;
                    m1_fault_out      = fault_in | expire;
                    m1_read_value_out = expire ? 32'h0 : read_value_in;
                end
            end
            default: ;
        endcase
    end

endmodule
